// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: PC, single-outstanding memory requests and a tagged prefetch FIFO.
// Optional PREFETCH_STATS_EN adds saturating push/redirect counters.
module fetch_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned PC_STEP  = 2,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_sys,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_instr,
`ifdef PREFETCH_STATS_EN
   output logic [15:0]       out_fetch_cnt,
   output logic [15:0]       out_flush_cnt,
`endif
   output logic [ADDR_W-1:0] out_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic push_c;
   logic pop_c;
   logic issue_c;

   // A response is kept only when it belongs to a live (non-squashed) request.
   assign push_c    = (state_q == ST_WAIT) && mem_ack && !redirect;
   assign pop_c     = out_valid && !stall && !redirect;
   assign issue_c   = (state_q == ST_IDLE) && !halt_sys && !redirect &&
                      (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0) && !halt_sys;
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         pc_q     <= ADDR_W'(RESET_PC);
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[PTR_W'(i)]    <= '0;
            instr_mem_q[PTR_W'(i)] <= '0;
         end
      end else begin
         if (push_c) begin
            pc_mem_q[wr_ptr_q]    <= mem_addr;
            instr_mem_q[wr_ptr_q] <= mem_rdata;
         end

         // Redirect flushes the buffer and retargets the PC; it never issues.
         if (redirect) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pc_q     <= redirect_pc;
         end else begin
            count_q  <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_c);
            if (issue_c) begin
               pc_q <= pc_q + ADDR_W'(PC_STEP);
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (issue_c) begin
                  mem_req  <= 1'b1;
                  mem_addr <= pc_q;
                  state_q  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (redirect) begin
                  state_q <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] flush_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (push_c && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         end
         if (redirect && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign out_fetch_cnt = fetch_cnt_q;
   assign out_flush_cnt = flush_cnt_q;
`endif

endmodule
